trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath/address width.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, meaning minimum pipeline-drain cycles (legal range 1..15).
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_ex, input, 1, illegal-instruction event.
REQ-006 SHALL have port i_ex_inst_addr, input, 1, instruction-address-misaligned event.
REQ-007 SHALL have port i_ex_ld_addr, input, 1, load-address-misaligned event.
REQ-008 SHALL have port i_ex_st_addr, input, 1, store-address-misaligned event.
REQ-009 SHALL have port i_ecall, input, 1, ECALL decoded.
REQ-010 SHALL have port i_ebreak, input, 1, EBREAK decoded.
REQ-011 SHALL have port i_eret, input, 1, MRET decoded.
REQ-012 SHALL have port i_tvec, input, XLEN, trap vector from CSR file.
REQ-013 SHALL have port i_epc, input, XLEN, return PC from CSR file.
REQ-014 SHALL have port i_stall, input, 1, memory/pipeline busy; blocks leaving drain.
REQ-015 SHALL have port i_fetch_ready, input, 1, fetch accepts redirect.
REQ-016 SHALL have port o_flush, output, 1, squash all in-flight instructions.
REQ-017 SHALL have port o_redirect_valid, output, 1, redirect PC valid.
REQ-018 SHALL have port o_redirect_pc, output, XLEN, redirect target.
REQ-019 SHALL have port o_trap_taken, output, 1, one-cycle pulse: CSR commits mepc/mcause.
REQ-020 SHALL have port o_eret_taken, output, 1, one-cycle pulse: MRET committed.
REQ-021 SHALL have port o_cause, output, 4, latched cause code of the current trap.
REQ-022 SHALL have port o_busy, output, 1, high whenever state is not IDLE.

Function
REQ-023 SHALL implement FSM states IDLE, DRAIN, REDIRECT.
REQ-024 In IDLE, any event sampled high at a clock edge SHALL move the FSM to DRAIN.
REQ-025 On simultaneous exception events, cause priority SHALL be inst_addr(0) > illegal(2) > ebreak(3) > ecall(11) > load(4) > store(6); only the winner is latched into o_cause.
REQ-026 i_eret SHALL be ignored whenever any exception event is high in the same cycle.
REQ-027 On exception entry, o_redirect_pc SHALL latch {i_tvec[XLEN-1:2],2'b00}; on eret entry it SHALL latch {i_epc[XLEN-1:2],2'b00}; both held until return to IDLE.
REQ-028 o_trap_taken (exception) or o_eret_taken (eret) SHALL be high for exactly the first DRAIN cycle; o_cause SHALL be 0 for eret entries.
REQ-029 On DRAIN entry a 4-bit counter SHALL load FLUSH_CYCLES-1 and decrement each DRAIN cycle, saturating at 0.
REQ-030 DRAIN SHALL exit to REDIRECT at the edge where counter==0 and i_stall==0; DRAIN therefore lasts at least FLUSH_CYCLES cycles.
REQ-031 o_flush SHALL be high in DRAIN and REDIRECT, low in IDLE.
REQ-032 In REDIRECT, o_redirect_valid SHALL be high; at the edge where i_fetch_ready==1 the FSM SHALL return to IDLE.
REQ-033 Events arriving while not in IDLE SHALL be ignored (squashed by flush), including in the cycle REDIRECT completes.
REQ-034 o_redirect_pc and o_cause SHALL retain their last values in IDLE.

Reset
REQ-035 Asserting i_rst low SHALL immediately force IDLE, counter 0, o_flush 0, o_redirect_valid 0, o_trap_taken 0, o_eret_taken 0, o_busy 0, o_cause 0, o_redirect_pc 0, regardless of clock.
REQ-036 Reset asserted mid-DRAIN or mid-REDIRECT SHALL abort the trap with no further pulses; after release the FSM SHALL accept a new event on the next edge.

Verification
REQ-037 i_ex_ld_addr=1 one cycle, i_tvec=0x0000_0103, i_stall=0, i_fetch_ready=1 -> o_trap_taken pulse next cycle, o_cause=4, DRAIN 2 cycles, REDIRECT 1 cycle with o_redirect_pc=0x0000_0100, then IDLE.
REQ-038 i_ex_inst_addr, i_ex and i_ecall high together -> o_cause=0, exactly one o_trap_taken pulse.
REQ-039 i_eret=1, i_epc=0x0000_2004 -> o_eret_taken pulse, o_cause=0, o_redirect_pc=0x0000_2004; i_eret with i_ebreak -> o_cause=3, o_eret_taken stays 0.
REQ-040 i_stall held high 5 cycles after entry -> DRAIN lasts 5 cycles, REDIRECT on first cycle after stall drops; i_fetch_ready low 3 cycles -> o_redirect_valid held 4 cycles.
REQ-041 i_ecall during DRAIN -> ignored, o_cause unchanged, single pulse.
REQ-042 i_rst low between clock edges mid-REDIRECT -> all outputs 0 immediately; after release i_ebreak -> normal trap with o_cause=3.

Source files
------------

// File: rtl/trap_ctrl.sv
// Trap/return sequencer: latches the winning trap cause and target, drains the
// pipeline for a bounded number of cycles, then redirects fetch.
module trap_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ex,
  input  logic            i_ex_inst_addr,
  input  logic            i_ex_ld_addr,
  input  logic            i_ex_st_addr,
  input  logic            i_ecall,
  input  logic            i_ebreak,
  input  logic            i_eret,
  input  logic [XLEN-1:0] i_tvec,
  input  logic [XLEN-1:0] i_epc,
  input  logic            i_stall,
  input  logic            i_fetch_ready,
  output logic            o_flush,
  output logic            o_redirect_valid,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_trap_taken,
  output logic            o_eret_taken,
  output logic [3:0]      o_cause,
  output logic            o_busy
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CAUSE_W = 4;

  localparam logic [CNT_W-1:0]   CNT_INIT   = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [XLEN-1:0]    ALIGN_MASK = ~XLEN'(3);

  localparam logic [CAUSE_W-1:0] CAUSE_INST_ADDR = CAUSE_W'(0);
  localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL   = CAUSE_W'(2);
  localparam logic [CAUSE_W-1:0] CAUSE_EBREAK    = CAUSE_W'(3);
  localparam logic [CAUSE_W-1:0] CAUSE_LD_ADDR   = CAUSE_W'(4);
  localparam logic [CAUSE_W-1:0] CAUSE_ST_ADDR   = CAUSE_W'(6);
  localparam logic [CAUSE_W-1:0] CAUSE_ECALL     = CAUSE_W'(11);
  localparam logic [CAUSE_W-1:0] CAUSE_NONE      = CAUSE_W'(0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CAUSE_W-1:0]   cause_q, cause_d;
  logic [XLEN-1:0]      pc_q, pc_d;
  logic                 flush_q, flush_d;
  logic                 rv_q, rv_d;
  logic                 busy_q, busy_d;
  logic                 trap_q, trap_d;
  logic                 eret_q, eret_d;

  logic                 exc_any_c;
  logic [CAUSE_W-1:0]   exc_cause_c;

  // Fixed-priority cause selection among simultaneous exception events
  always_comb begin
    exc_any_c   = i_ex_inst_addr | i_ex | i_ebreak | i_ecall | i_ex_ld_addr | i_ex_st_addr;
    exc_cause_c = CAUSE_ST_ADDR;
    if (i_ex_inst_addr)    exc_cause_c = CAUSE_INST_ADDR;
    else if (i_ex)         exc_cause_c = CAUSE_ILLEGAL;
    else if (i_ebreak)     exc_cause_c = CAUSE_EBREAK;
    else if (i_ecall)      exc_cause_c = CAUSE_ECALL;
    else if (i_ex_ld_addr) exc_cause_c = CAUSE_LD_ADDR;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cause_q <= '0;
      pc_q    <= '0;
      flush_q <= 1'b0;
      rv_q    <= 1'b0;
      busy_q  <= 1'b0;
      trap_q  <= 1'b0;
      eret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      rv_q    <= rv_d;
      busy_q  <= busy_d;
      trap_q  <= trap_d;
      eret_q  <= eret_d;
    end
  end

  // Next state; outputs are precomputed from the next state so they come out of flops
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    pc_d    = pc_q;
    trap_d  = 1'b0;
    eret_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (exc_any_c) begin
          state_d = DRAIN;
          cnt_d   = CNT_INIT;
          cause_d = exc_cause_c;
          pc_d    = i_tvec & ALIGN_MASK;
          trap_d  = 1'b1;
        end else if (i_eret) begin
          state_d = DRAIN;
          cnt_d   = CNT_INIT;
          cause_d = CAUSE_NONE;
          pc_d    = i_epc & ALIGN_MASK;
          eret_d  = 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == '0 && !i_stall) begin
          state_d = REDIRECT;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      REDIRECT: begin
        if (i_fetch_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    flush_d = (state_d != IDLE);
    busy_d  = (state_d != IDLE);
    rv_d    = (state_d == REDIRECT);
  end

  assign o_flush          = flush_q;
  assign o_redirect_valid = rv_q;
  assign o_redirect_pc    = pc_q;
  assign o_trap_taken     = trap_q;
  assign o_eret_taken     = eret_q;
  assign o_cause          = cause_q;
  assign o_busy           = busy_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Randomized scoreboard bench for trap_ctrl: a driver issues trap/return events
// and pushes expected outcomes; a monitor checks each observed trap sequence.
module tb_trap_ctrl;

  localparam int unsigned XLEN = 32;
  localparam int unsigned FC   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            ex, ex_inst, ex_ld, ex_st, ecall, ebreak, eret;
  logic [XLEN-1:0] tvec, epc;
  logic            stall, fetch_ready;
  logic            flush, rv, trap_taken, eret_taken, busy;
  logic [XLEN-1:0] rpc;
  logic [3:0]      cause;

  trap_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ex(ex), .i_ex_inst_addr(ex_inst), .i_ex_ld_addr(ex_ld), .i_ex_st_addr(ex_st),
    .i_ecall(ecall), .i_ebreak(ebreak), .i_eret(eret),
    .i_tvec(tvec), .i_epc(epc), .i_stall(stall), .i_fetch_ready(fetch_ready),
    .o_flush(flush), .o_redirect_valid(rv), .o_redirect_pc(rpc),
    .o_trap_taken(trap_taken), .o_eret_taken(eret_taken), .o_cause(cause), .o_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_eret;
    logic [3:0]  cause;
    logic [31:0] pc;
    int          dlen;
    int          rlen;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ev bits: 0 inst_addr, 1 illegal, 2 ebreak, 3 ecall, 4 load, 5 store, 6 eret
  task automatic set_ev(input logic [6:0] ev);
    ex_inst = ev[0]; ex = ev[1]; ebreak = ev[2]; ecall = ev[3];
    ex_ld = ev[4]; ex_st = ev[5]; eret = ev[6];
  endtask

  // Reference: outcome of one trap request, from cause priority and timing rules
  function automatic exp_t model(input logic [6:0] ev, input logic [31:0] tv,
                                 input logic [31:0] ep, input int s, input int f);
    exp_t e;
    e.is_eret = (ev[5:0] == 6'd0);
    if (ev[0])      e.cause = 4'd0;
    else if (ev[1]) e.cause = 4'd2;
    else if (ev[2]) e.cause = 4'd3;
    else if (ev[3]) e.cause = 4'd11;
    else if (ev[4]) e.cause = 4'd4;
    else if (ev[5]) e.cause = 4'd6;
    else            e.cause = 4'd0;
    e.pc      = e.is_eret ? ep : tv;
    e.pc[1:0] = 2'b00;
    e.dlen    = (s > FC) ? s : FC;
    e.rlen    = f + 1;
    return e;
  endfunction

  // s: cycles stall is high starting with the event cycle; f: redirect cycles with fetch_ready low
  task automatic run_txn(input logic [6:0] ev, input logic [31:0] tv, input logic [31:0] ep,
                         input int s, input int f, input bit noise);
    int c, r, guard;
    set_ev(ev); tvec = tv; epc = ep;
    stall = (s >= 1); fetch_ready = 1'($urandom);
    if (ev != 7'd0) exp_q.push_back(model(ev, tv, ep, s, f));
    @(posedge clk); #1;
    if (ev == 7'd0) begin
      set_ev(7'd0);
      return;
    end
    c = 1; r = 0; guard = 0;
    while (guard < 200) begin
      set_ev(7'd0);
      if (rv) begin
        fetch_ready = (r >= f); stall = 1'($urandom); r++;
      end else if (busy) begin
        stall = (c < s); fetch_ready = 1'($urandom); c++;
      end else break;
      if (noise && ($urandom % 2 == 0)) begin
        set_ev(7'($urandom)); tvec = $urandom; epc = $urandom;
      end
      @(posedge clk); #1; guard++;
    end
    set_ev(7'd0);
    if (guard >= 200) chk("txn_timeout", 64'(guard), 64'd0);
  endtask

  // Monitor: each trap/eret pulse starts a sequence that is measured and scored
  initial begin : monitor
    exp_t e;
    int   dlen, rlen, extra, guard;
    bit   busy_bad, pc_bad, cause_bad;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (trap_taken || eret_taken) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {62'd0, trap_taken, eret_taken}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", {62'd0, trap_taken, eret_taken}, e.is_eret ? 64'd1 : 64'd2);
          chk("entry_cause", 64'(cause), 64'(e.cause));
          chk("entry_flush", {62'd0, flush, busy}, 64'd3);
          dlen = 1; rlen = 0; extra = 0; guard = 0;
          busy_bad = 0; pc_bad = 0; cause_bad = 0;
          @(negedge clk);
          while (flush && !rv && guard < 300) begin
            extra += int'(trap_taken) + int'(eret_taken);
            busy_bad |= (busy !== flush);
            cause_bad |= (cause !== e.cause);
            dlen++; guard++;
            @(negedge clk);
          end
          while (rv && guard < 300) begin
            extra += int'(trap_taken) + int'(eret_taken);
            busy_bad |= (busy !== 1'b1) || (flush !== 1'b1);
            pc_bad |= (rpc !== e.pc);
            cause_bad |= (cause !== e.cause);
            rlen++; guard++;
            @(negedge clk);
          end
          chk("drain_len", 64'(dlen), 64'(e.dlen));
          chk("redirect_len", 64'(rlen), 64'(e.rlen));
          chk("redirect_pc", {63'd0, pc_bad}, 64'd0);
          chk("cause_stable", {63'd0, cause_bad}, 64'd0);
          chk("busy_flush_track", {63'd0, busy_bad}, 64'd0);
          chk("extra_pulses", 64'(extra), 64'd0);
          chk("idle_ctrl", {60'd0, flush, rv, busy, trap_taken | eret_taken}, 64'd0);
          chk("idle_keep_pc", 64'(rpc), 64'(e.pc));
          chk("idle_keep_cause", 64'(cause), 64'(e.cause));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int guard;
    rst = 1'b0; set_ev(7'd0); tvec = '0; epc = '0; stall = 1'b0; fetch_ready = 1'b1;
    #2;
    chk("reset_outputs", {rpc, 23'd0, cause, flush, rv, trap_taken, eret_taken, busy}, 64'd0);
    @(negedge clk); rst = 1'b1;

    // Reset between edges while in REDIRECT, then a fresh ebreak trap
    @(posedge clk); #1;
    set_ev(7'b0001000); tvec = 32'h0000_4002; fetch_ready = 1'b0;
    @(posedge clk); #1;
    set_ev(7'd0);
    chk("pre_rst_pulse", {60'd0, cause, trap_taken}, {59'd0, 4'd11, 1'b1});
    guard = 0;
    while (!rv && guard < 20) begin @(posedge clk); #1; guard++; end
    chk("reach_redirect", {63'd0, rv}, 64'd1);
    #1 rst = 1'b0;
    #1 chk("async_rst_outputs", {rpc, 23'd0, cause, flush, rv, trap_taken, eret_taken, busy}, 64'd0);
    #1 rst = 1'b1; set_ev(7'b0000100); tvec = 32'h0000_0800; fetch_ready = 1'b1;
    @(posedge clk); #1;
    set_ev(7'd0);
    chk("post_rst_trap", {27'd0, rpc, cause, trap_taken}, {27'd0, 32'h0000_0800, 4'd3, 1'b1});
    guard = 0;
    while (busy && guard < 20) begin @(posedge clk); #1; guard++; end
    chk("post_rst_idle", {63'd0, busy}, 64'd0);

    mon_en = 1;
    // Directed cases
    run_txn(7'b0010000, 32'h0000_0103, 32'h0, 0, 0, 0);
    run_txn(7'b0001011, 32'h0000_0200, 32'h0, 0, 0, 0);
    run_txn(7'b1000000, 32'h0, 32'h0000_2004, 0, 0, 0);
    run_txn(7'b1000100, 32'h0000_0300, 32'h0000_2004, 0, 0, 0);
    run_txn(7'b0100000, 32'h0000_0400, 32'h0, 5, 3, 0);
    run_txn(7'b0001000, 32'h0000_0500, 32'h0, 0, 1, 1);
    run_txn(7'd0, 32'h0, 32'h0, 0, 0, 0);
    // Random traffic
    for (int i = 0; i < 60; i++) begin
      logic [6:0] ev;
      case ($urandom % 5)
        0: ev = 7'b1000000;
        1: ev = 7'(1 << ($urandom % 6));
        2: ev = 7'd0;
        default: ev = 7'($urandom);
      endcase
      run_txn(ev, $urandom, $urandom, int'($urandom % 7), int'($urandom % 5), 1'($urandom));
    end
    repeat (6) @(posedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
